// File: rtl/divclk_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : divclk_ctrl
//  Brief    : Sequencer for a T-flip-flop clock divider. Generates the
//             registered toggle-enable train, mirrors the divided output,
//             and swaps in new half-period values only at period ends.
//  Revision : 1.0 - initial release
// ============================================================================
module divclk_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_half,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             t_out,
   output logic             q,
   output logic             period_done,
   output logic             busy
);

   localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_STOPPING = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_active_half;
   logic [CNT_W-1:0] r_pend_half;
   logic             r_pend_valid;
   logic             r_t_out;
   logic             r_q;
   logic             r_period_done;
   logic             r_cfg_err;

   logic             w_wrap;
   logic             w_q_nxt;
   logic             w_period_end;
   logic             w_cfg_acc;
   logic             w_cfg_zero;
   logic             w_apply;

   // The counter only runs outside IDLE; a wrap marks the end of a half-period.
   assign w_wrap       = (r_state != ST_IDLE) && (r_cnt == (r_active_half - c_CNT_ONE));
   // Value q takes after this edge. Using it (rather than q itself) keeps the
   // period-end decision correct when N = 1 and a toggle is already in flight.
   assign w_q_nxt      = r_q ^ r_t_out;
   // End of a full period: the high half has just completed and q will fall.
   assign w_period_end = w_wrap && w_q_nxt;

   assign w_cfg_acc    = cfg_valid && !r_pend_valid;
   assign w_cfg_zero   = (cfg_half == '0);
   // A pending value is applied at a period end. A value parked on the very
   // edge the block dropped to IDLE is applied in IDLE so it cannot get stuck.
   assign w_apply      = r_pend_valid && (w_period_end || (r_state == ST_IDLE));

   assign cfg_ready    = !r_pend_valid;
   assign cfg_err      = r_cfg_err;
   assign t_out        = r_t_out;
   assign q            = r_q;
   assign period_done  = r_period_done;
   assign busy         = (r_state != ST_IDLE) || r_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: stopping only completes at a period end so no runt occurs.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (run) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!run) w_state_nxt = ST_STOPPING;
         end
         ST_STOPPING: begin
            if (run)               w_state_nxt = ST_RUN;
            else if (w_period_end) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Half-period counter, toggle-enable pulse, divided-output mirror and pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt         <= '0;
         r_t_out       <= 1'b0;
         r_q           <= 1'b0;
         r_period_done <= 1'b0;
         r_cfg_err     <= 1'b0;
      end else begin
         if (r_state == ST_IDLE || w_wrap) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
         end
         r_t_out       <= w_wrap;
         r_q           <= w_q_nxt;
         r_period_done <= r_t_out && r_q;
         r_cfg_err     <= w_cfg_acc && w_cfg_zero;
      end
   end

   // Half-period registers: direct load in IDLE, otherwise park until a period end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active_half <= c_CNT_ONE;
         r_pend_half   <= '0;
         r_pend_valid  <= 1'b0;
      end else begin
         if (w_apply) begin
            r_active_half <= r_pend_half;
            r_pend_valid  <= 1'b0;
         end
         // Acceptance needs an empty pend slot, so it never collides with an apply.
         if (w_cfg_acc && !w_cfg_zero) begin
            if (r_state == ST_IDLE) begin
               r_active_half <= cfg_half;
            end else begin
               r_pend_half  <= cfg_half;
               r_pend_valid <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_divclk_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_divclk_ctrl
//  Brief    : Self-checking bench for divclk_ctrl. Expected output values are
//             queued per clock edge when stimulus is applied and compared at
//             the following falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_divclk_ctrl;

   localparam int CNT_W = 16;

   localparam int SEL_Q    = 0;
   localparam int SEL_TOUT = 1;
   localparam int SEL_PD   = 2;
   localparam int SEL_RDY  = 3;
   localparam int SEL_ERR  = 4;
   localparam int SEL_BUSY = 5;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             run;
   logic             cfg_valid;
   logic [CNT_W-1:0] cfg_half;
   logic             cfg_ready;
   logic             cfg_err;
   logic             t_out;
   logic             q;
   logic             period_done;
   logic             busy;

   typedef struct {
      int    cyc;
      int    sel;
      logic  val;
      string tag;
   } exp_t;

   exp_t sb[$];
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   divclk_ctrl #(.CNT_W(CNT_W)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .cfg_valid   (cfg_valid),
      .cfg_half    (cfg_half),
      .cfg_ready   (cfg_ready),
      .cfg_err     (cfg_err),
      .t_out       (t_out),
      .q           (q),
      .period_done (period_done),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Edge counter: cyc = number of rising edges seen so far.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic sig_of(input int sel);
      case (sel)
         SEL_Q:    return q;
         SEL_TOUT: return t_out;
         SEL_PD:   return period_done;
         SEL_RDY:  return cfg_ready;
         SEL_ERR:  return cfg_err;
         default:  return busy;
      endcase
   endfunction

   function automatic string sel_name(input int sel);
      case (sel)
         SEL_Q:    return "q";
         SEL_TOUT: return "t_out";
         SEL_PD:   return "period_done";
         SEL_RDY:  return "cfg_ready";
         SEL_ERR:  return "cfg_err";
         default:  return "busy";
      endcase
   endfunction

   // Queue an expected value of one output, as seen after edge base+off.
   task automatic push(input string grp, input int base, input int off, input int sel, input logic val);
      exp_t e;
      e.cyc = base + off;
      e.sel = sel;
      e.val = val;
      e.tag = $sformatf("%s.%s@+%0d", grp, sel_name(sel), off);
      sb.push_back(e);
   endtask

   // Scoreboard: compare every entry due at this edge, away from the rising edge.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            check_eq(sb[i].tag, {31'd0, sig_of(sb[i].sel)}, {31'd0, sb[i].val});
            sb.delete(i);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Advance so that inputs driven next are sampled at rising edge c.
   task automatic to_edge(input int c);
      while (cyc < c - 1) step(1);
   endtask

   task automatic offer_cfg(input logic [CNT_W-1:0] v);
      cfg_valid = 1'b1;
      cfg_half  = v;
      step(1);
      cfg_valid = 1'b0;
      cfg_half  = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      int f0;
      int g0;
      int waited;

      rst_n     = 1'b0;
      run       = 1'b0;
      cfg_valid = 1'b0;
      cfg_half  = '0;
      #12;
      check_eq("rst.q",           {31'd0, q},           32'd0);
      check_eq("rst.t_out",       {31'd0, t_out},       32'd0);
      check_eq("rst.period_done", {31'd0, period_done}, 32'd0);
      check_eq("rst.cfg_err",     {31'd0, cfg_err},     32'd0);
      check_eq("rst.busy",        {31'd0, busy},        32'd0);
      check_eq("rst.cfg_ready",   {31'd0, cfg_ready},   32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      step(2);

      // Default N = 1: t_out constant high, q = clk/2.
      run = 1'b1;
      step(1);
      e0 = cyc;
      for (int k = 0; k <= 8; k++) begin
         push("n1", e0, k, SEL_TOUT, k >= 1);
         push("n1", e0, k, SEL_Q,    (k >= 2) && (k % 2 == 0));
         push("n1", e0, k, SEL_PD,   (k >= 3) && (k % 2 == 1));
      end
      to_edge(e0 + 9);
      run = 1'b0;
      step(1);
      waited = 0;
      while (busy && waited < 20) begin
         step(1);
         waited++;
      end
      check_eq("n1.stop_busy",  {31'd0, busy},  32'd0);
      check_eq("n1.stop_q",     {31'd0, q},     32'd0);
      step(1);
      check_eq("n1.stop_t_out", {31'd0, t_out}, 32'd0);

      // N = 3 loaded in IDLE, then a run start.
      offer_cfg(16'd3);
      check_eq("n3.cfg_ready", {31'd0, cfg_ready}, 32'd1);
      run = 1'b1;
      step(1);
      e0 = cyc;
      for (int k = 0; k <= 12; k++) begin
         push("n3", e0, k, SEL_TOUT, (k >= 3) && (k % 3 == 0));
         push("n3", e0, k, SEL_Q,    (k >= 4) && (((k - 4) / 3) % 2 == 0));
         push("n3", e0, k, SEL_PD,   (k >= 7) && ((k - 7) % 6 == 0));
      end

      // N = 5 offered mid high phase: parked, applied at the period end.
      to_edge(e0 + 11);
      offer_cfg(16'd5);
      push("n5", e0, 11, SEL_RDY,  1'b0);
      push("n5", e0, 12, SEL_RDY,  1'b1);
      push("n5", e0, 13, SEL_Q,    1'b0);
      push("n5", e0, 16, SEL_TOUT, 1'b0);
      push("n5", e0, 17, SEL_Q,    1'b0);
      push("n5", e0, 17, SEL_TOUT, 1'b1);
      push("n5", e0, 18, SEL_Q,    1'b1);
      push("n5", e0, 22, SEL_Q,    1'b1);
      push("n5", e0, 23, SEL_Q,    1'b0);

      // Illegal zero: accepted, flagged, dropped.
      to_edge(e0 + 19);
      offer_cfg(16'd0);
      push("zero", e0, 19, SEL_ERR, 1'b1);
      push("zero", e0, 19, SEL_RDY, 1'b1);
      push("zero", e0, 20, SEL_ERR, 1'b0);

      // N = 4 parked during the N = 5 low phase, applied after the next high phase.
      to_edge(e0 + 24);
      offer_cfg(16'd4);
      push("n4", e0, 24, SEL_RDY,  1'b0);
      push("n4", e0, 27, SEL_Q,    1'b0);
      push("n4", e0, 28, SEL_Q,    1'b1);
      push("n4", e0, 32, SEL_Q,    1'b1);
      push("n4", e0, 32, SEL_RDY,  1'b1);
      push("n4", e0, 33, SEL_Q,    1'b0);
      push("n4", e0, 36, SEL_Q,    1'b0);
      push("n4", e0, 36, SEL_TOUT, 1'b1);
      push("n4", e0, 37, SEL_Q,    1'b1);
      push("n4", e0, 40, SEL_Q,    1'b1);

      // Stop requested while q is high: finishes the high phase, ends low in IDLE.
      to_edge(e0 + 38);
      run = 1'b0;
      step(1);
      push("stop", e0, 40, SEL_BUSY, 1'b1);
      push("stop", e0, 40, SEL_TOUT, 1'b1);
      push("stop", e0, 41, SEL_Q,    1'b0);
      push("stop", e0, 41, SEL_BUSY, 1'b0);
      push("stop", e0, 41, SEL_TOUT, 1'b0);
      push("stop", e0, 41, SEL_PD,   1'b1);
      push("stop", e0, 45, SEL_Q,    1'b0);
      push("stop", e0, 45, SEL_BUSY, 1'b0);
      to_edge(e0 + 47);

      // Restart at N = 4, brief stop request that is withdrawn: no gap, no runt.
      run = 1'b1;
      step(1);
      f0 = cyc;
      push("rerun", f0, 4,  SEL_TOUT, 1'b1);
      push("rerun", f0, 4,  SEL_Q,    1'b0);
      push("rerun", f0, 5,  SEL_Q,    1'b1);
      push("rerun", f0, 7,  SEL_BUSY, 1'b1);
      push("rerun", f0, 8,  SEL_Q,    1'b1);
      push("rerun", f0, 8,  SEL_TOUT, 1'b1);
      push("rerun", f0, 9,  SEL_Q,    1'b0);
      push("rerun", f0, 12, SEL_Q,    1'b0);
      push("rerun", f0, 12, SEL_TOUT, 1'b1);
      push("rerun", f0, 13, SEL_Q,    1'b1);
      to_edge(f0 + 6);
      run = 1'b0;
      step(1);
      run = 1'b1;
      step(1);

      // Park a config, then reset asynchronously mid high phase.
      to_edge(f0 + 14);
      offer_cfg(16'd7);
      push("arst", f0, 14, SEL_RDY, 1'b0);
      step(1);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("arst.q",           {31'd0, q},           32'd0);
      check_eq("arst.t_out",       {31'd0, t_out},       32'd0);
      check_eq("arst.cfg_err",     {31'd0, cfg_err},     32'd0);
      check_eq("arst.period_done", {31'd0, period_done}, 32'd0);
      check_eq("arst.busy",        {31'd0, busy},        32'd0);
      check_eq("arst.cfg_ready",   {31'd0, cfg_ready},   32'd1);
      run = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(2);
      check_eq("post_rst.cfg_ready", {31'd0, cfg_ready}, 32'd1);

      // After reset the half-period is back to 1.
      run = 1'b1;
      step(1);
      g0 = cyc;
      push("post_rst", g0, 1, SEL_TOUT, 1'b1);
      push("post_rst", g0, 1, SEL_Q,    1'b0);
      push("post_rst", g0, 2, SEL_Q,    1'b1);
      push("post_rst", g0, 2, SEL_BUSY, 1'b1);
      push("post_rst", g0, 3, SEL_Q,    1'b0);
      push("post_rst", g0, 3, SEL_PD,   1'b1);
      step(5);
      check_eq("sb_drain", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
